// File: rtl/ddr_ex_pattern_checker.sv
// Read-side pattern checker: regenerates per-lane LFSR write data and scores each read beat.
// Optional first-error capture is built only when DDR_EX_CHECKER_ERR_CAPTURE_EN is defined.
module ddr_ex_pattern_checker #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned SEED_BASE = 32,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          num_beats,
  input  logic                 rd_valid,
  input  logic [8*LANES-1:0]   rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [LANES-1:0]     pnf_per_lane,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [15:0]          beat_count,
  output logic                 cmp_valid,
  output logic                 cmp_ok,
  output logic [15:0]          first_err_beat,
  output logic [8*LANES-1:0]   first_err_data,
  output logic [8*LANES-1:0]   first_err_exp
);

  localparam int unsigned DW = 8 * LANES;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic logic [7:0] lfsr_step(input logic [7:0] d);
    return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
  endfunction

  function automatic logic [DW-1:0] seed_vec();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(LANES); i++) v[8*i +: 8] = 8'((SEED_BASE + 32'(i)) % 256);
    return v;
  endfunction

  logic [1:0]           state_q, state_n;
  logic [DW-1:0]        lfsr_q, lfsr_n, lfsr_step_v;
  logic [LANES-1:0]     pnf_q, pnf_n, mism;
  logic [ERR_CNT_W-1:0] err_q, err_n;
  logic [15:0]          beat_q, beat_n, num_q, num_n;
  logic                 busy_n, done_n, pass_n, cmp_valid_n, cmp_ok_n;
  logic                 fail_beat;

  // Per-lane compare against the current expected byte, and the stepped LFSR value
  always_comb begin
    mism        = '0;
    lfsr_step_v = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      mism[i]                = rd_data[8*i +: 8] != lfsr_q[8*i +: 8];
      lfsr_step_v[8*i +: 8]  = lfsr_step(lfsr_q[8*i +: 8]);
    end
  end

  // Next-state and next-status logic; start overrides any beat in the same cycle
  always_comb begin
    state_n     = state_q;
    lfsr_n      = lfsr_q;
    pnf_n       = pnf_q;
    err_n       = err_q;
    beat_n      = beat_q;
    num_n       = num_q;
    cmp_valid_n = 1'b0;
    cmp_ok_n    = cmp_ok;
    fail_beat   = 1'b0;
    if (start) begin
      lfsr_n  = seed_vec();
      pnf_n   = '1;
      err_n   = '0;
      beat_n  = '0;
      num_n   = num_beats;
      state_n = (num_beats == 16'd0) ? DONE : CHECK;
    end else begin
      case (state_q)
        CHECK: begin
          if (rd_valid) begin
            fail_beat   = |mism;
            lfsr_n      = lfsr_step_v;
            pnf_n       = pnf_q & ~mism;
            beat_n      = beat_q + 16'd1;
            cmp_valid_n = 1'b1;
            cmp_ok_n    = ~fail_beat;
            if (fail_beat && (err_q != '1)) err_n = err_q + ERR_CNT_W'(1);
            if (beat_n == num_q) state_n = DONE;
          end
        end
        IDLE, DONE: state_n = state_q;
        default:    state_n = IDLE;
      endcase
    end
    busy_n = state_n == CHECK;
    done_n = state_n == DONE;
    pass_n = done_n && (&pnf_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= seed_vec();
      pnf_q     <= '1;
      err_q     <= '0;
      beat_q    <= '0;
      num_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_ok    <= 1'b0;
    end else begin
      state_q   <= state_n;
      lfsr_q    <= lfsr_n;
      pnf_q     <= pnf_n;
      err_q     <= err_n;
      beat_q    <= beat_n;
      num_q     <= num_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      cmp_valid <= cmp_valid_n;
      cmp_ok    <= cmp_ok_n;
    end
  end

  assign pnf_per_lane = pnf_q;
  assign err_count    = err_q;
  assign beat_count   = beat_q;

`ifdef DDR_EX_CHECKER_ERR_CAPTURE_EN
  logic [15:0]   fe_beat_q, fe_beat_n;
  logic [DW-1:0] fe_data_q, fe_data_n, fe_exp_q, fe_exp_n;

  // err_q is zero exactly until the first failing beat of a run
  always_comb begin
    fe_beat_n = fe_beat_q;
    fe_data_n = fe_data_q;
    fe_exp_n  = fe_exp_q;
    if (start) begin
      fe_beat_n = '0;
      fe_data_n = '0;
      fe_exp_n  = '0;
    end else if (fail_beat && (err_q == '0)) begin
      fe_beat_n = beat_q;
      fe_data_n = rd_data;
      fe_exp_n  = lfsr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fe_beat_q <= '0;
      fe_data_q <= '0;
      fe_exp_q  <= '0;
    end else begin
      fe_beat_q <= fe_beat_n;
      fe_data_q <= fe_data_n;
      fe_exp_q  <= fe_exp_n;
    end
  end

  assign first_err_beat = fe_beat_q;
  assign first_err_data = fe_data_q;
  assign first_err_exp  = fe_exp_q;
`else
  assign first_err_beat = '0;
  assign first_err_data = '0;
  assign first_err_exp  = '0;
`endif

endmodule

// File: tb/tb_ddr_ex_pattern_checker.sv
// Directed bench for ddr_ex_pattern_checker; a second instance with a 2-bit error counter covers saturation.
module tb_ddr_ex_pattern_checker;

  logic        clk = 1'b0;
  logic        reset, start, rd_valid;
  logic [15:0] num_beats;
  logic [31:0] rd_data;

  logic        busy, done, pass, cmp_valid, cmp_ok;
  logic [3:0]  pnf_per_lane;
  logic [15:0] err_count, beat_count, first_err_beat;
  logic [31:0] first_err_data, first_err_exp;

  logic        s_busy, s_done, s_pass, s_cmp_valid, s_cmp_ok;
  logic [3:0]  s_pnf;
  logic [1:0]  s_err;
  logic [15:0] s_beat, s_fe_beat;
  logic [31:0] s_fe_data, s_fe_exp;

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed expected beats, lanes 3..0, seeds 0x23/0x22/0x21/0x20
  localparam logic [31:0] B0 = 32'h2322_2120;
  localparam logic [31:0] B1 = 32'h4644_4240;
  localparam logic [31:0] B2 = 32'h8C88_8480;
  localparam logic [31:0] B3 = 32'h050D_151D;

  always #5 clk = ~clk;

  ddr_ex_pattern_checker #(.LANES(4), .SEED_BASE(32), .ERR_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_beats(num_beats),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .pnf_per_lane(pnf_per_lane),
    .err_count(err_count), .beat_count(beat_count),
    .cmp_valid(cmp_valid), .cmp_ok(cmp_ok),
    .first_err_beat(first_err_beat), .first_err_data(first_err_data),
    .first_err_exp(first_err_exp)
  );

  ddr_ex_pattern_checker #(.LANES(4), .SEED_BASE(32), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .num_beats(num_beats),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(s_busy), .done(s_done), .pass(s_pass), .pnf_per_lane(s_pnf),
    .err_count(s_err), .beat_count(s_beat),
    .cmp_valid(s_cmp_valid), .cmp_ok(s_cmp_ok),
    .first_err_beat(s_fe_beat), .first_err_data(s_fe_data),
    .first_err_exp(s_fe_exp)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] n);
    start = 1'b1;
    num_beats = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic ok, input string tag);
    rd_valid = 1'b1;
    rd_data = d;
    @(negedge clk);
    rd_valid = 1'b0;
    check({tag, ".cmp_valid"}, cmp_valid, 1'b1);
    check({tag, ".cmp_ok"}, cmp_ok, ok);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("gap.cmp_valid", cmp_valid, 1'b0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
    check({tag, ".pass"}, pass, 1'b0);
    check({tag, ".cmp_valid"}, cmp_valid, 1'b0);
    check({tag, ".cmp_ok"}, cmp_ok, 1'b0);
    check({tag, ".pnf"}, pnf_per_lane, 4'hF);
    check({tag, ".err"}, err_count, 16'd0);
    check({tag, ".beat"}, beat_count, 16'd0);
    check({tag, ".fe_beat"}, first_err_beat, 16'd0);
    check({tag, ".fe_data"}, first_err_data, 32'd0);
    check({tag, ".fe_exp"}, first_err_exp, 32'd0);
    check({tag, ".s_err"}, s_err, 2'd0);
    check({tag, ".s_pnf"}, s_pnf, 4'hF);
    check({tag, ".s_busy"}, s_busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_data = '0; num_beats = '0;
    @(negedge clk); @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    // rd_valid in IDLE must be ignored
    rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    rd_valid = 1'b0;
    check("idle.cmp_valid", cmp_valid, 1'b0);
    check("idle.beat", beat_count, 16'd0);

    // Clean 4-beat run
    pulse_start(16'd4);
    check("t1.busy", busy, 1'b1);
    send(B0, 1'b1, "t1.b0");
    send(B1, 1'b1, "t1.b1");
    send(B2, 1'b1, "t1.b2");
    check("t1.done_early", done, 1'b0);
    send(B3, 1'b1, "t1.b3");
    check("t1.done", done, 1'b1);
    check("t1.busy_end", busy, 1'b0);
    check("t1.pass", pass, 1'b1);
    check("t1.err", err_count, 16'd0);
    check("t1.beat", beat_count, 16'd4);
    check("t1.pnf", pnf_per_lane, 4'hF);
    rd_valid = 1'b1; rd_data = 32'h0;
    @(negedge clk);
    rd_valid = 1'b0;
    check("t1.done_hold", done, 1'b1);
    check("t1.done_ignore", cmp_valid, 1'b0);
    check("t1.beat_hold", beat_count, 16'd4);

    // Lane2 bit0 flipped on beat 1
    pulse_start(16'd4);
    check("t2.pnf_clr", pnf_per_lane, 4'hF);
    check("t2.beat_clr", beat_count, 16'd0);
    send(B0, 1'b1, "t2.b0");
    send(32'h4645_4240, 1'b0, "t2.b1");
    send(B2, 1'b1, "t2.b2");
    send(B3, 1'b1, "t2.b3");
    check("t2.done", done, 1'b1);
    check("t2.pass", pass, 1'b0);
    check("t2.pnf", pnf_per_lane, 4'b1011);
    check("t2.err", err_count, 16'd1);
`ifdef DDR_EX_CHECKER_ERR_CAPTURE_EN
    check("t2.fe_beat", first_err_beat, 16'd1);
    check("t2.fe_data", first_err_data, 32'h4645_4240);
    check("t2.fe_exp", first_err_exp, B1);
`else
    check("t2.fe_beat", first_err_beat, 16'd0);
    check("t2.fe_data", first_err_data, 32'd0);
    check("t2.fe_exp", first_err_exp, 32'd0);
`endif

    // 3 beats with 2-cycle gaps
    pulse_start(16'd3);
    check("t3.err_clr", err_count, 16'd0);
    send(B0, 1'b1, "t3.b0");
    idle(2);
    check("t3.beat_gap", beat_count, 16'd1);
    send(B1, 1'b1, "t3.b1");
    idle(2);
    check("t3.busy_gap", busy, 1'b1);
    send(B2, 1'b1, "t3.b2");
    check("t3.done", done, 1'b1);
    check("t3.pass", pass, 1'b1);
    check("t3.beat", beat_count, 16'd3);

    // start collides with a beat mid-run
    pulse_start(16'd4);
    send(B0, 1'b1, "t4.b0");
    send(B1, 1'b1, "t4.b1");
    start = 1'b1; num_beats = 16'd4; rd_valid = 1'b1; rd_data = B2;
    @(negedge clk);
    start = 1'b0; rd_valid = 1'b0;
    check("t4.discard", cmp_valid, 1'b0);
    check("t4.beat_clr", beat_count, 16'd0);
    check("t4.busy", busy, 1'b1);
    send(B0, 1'b1, "t4.r0");
    check("t4.beat1", beat_count, 16'd1);
    send(B1, 1'b1, "t4.r1");
    send(B2, 1'b1, "t4.r2");
    send(B3, 1'b1, "t4.r3");
    check("t4.pass", pass, 1'b1);

    // num_beats = 0
    pulse_start(16'd0);
    check("t5.done", done, 1'b1);
    check("t5.pass", pass, 1'b1);
    check("t5.busy", busy, 1'b0);
    check("t5.cmp_valid", cmp_valid, 1'b0);
    rd_valid = 1'b1; rd_data = B0;
    @(negedge clk);
    rd_valid = 1'b0;
    check("t5.no_cmp", cmp_valid, 1'b0);
    check("t5.beat", beat_count, 16'd0);

    // All-zero data mismatches every lane (nonzero seeds never reach 0)
    pulse_start(16'd6);
    send(32'h0, 1'b0, "t6.b0");
    check("t6.s_err1", s_err, 2'd1);
    send(32'h0, 1'b0, "t6.b1");
    send(32'h0, 1'b0, "t6.b2");
    check("t6.s_err3", s_err, 2'd3);
    send(32'h0, 1'b0, "t6.b3");
    send(32'h0, 1'b0, "t6.b4");
    send(32'h0, 1'b0, "t6.b5");
    check("t6.s_sat", s_err, 2'd3);
    check("t6.s_pnf", s_pnf, 4'h0);
    check("t6.s_done", s_done, 1'b1);
    check("t6.s_pass", s_pass, 1'b0);
    check("t6.err", err_count, 16'd6);
    check("t6.pnf", pnf_per_lane, 4'h0);
`ifdef DDR_EX_CHECKER_ERR_CAPTURE_EN
    check("t6.fe_beat", first_err_beat, 16'd0);
    check("t6.fe_exp", first_err_exp, B0);
`endif

    // Reset mid-run
    pulse_start(16'd6);
    send(32'h0, 1'b0, "t7.b0");
    send(32'h0, 1'b0, "t7.b1");
    check("t7.err_pre", err_count, 16'd2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("t7");
    reset = 1'b0;
    @(negedge clk);
    check("t7.idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
